// File: rtl/pwm_core_pkg.sv
// Shared definitions for the PWM/buzzer core and the register file that feeds it.
// Holds the FSM state type, default widths and the cfg field slicing of the slave registers.
package pwm_core_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } core_state_t;

  localparam int CNT_W_DEF   = 16;
  localparam int PRESC_W_DEF = 8;

  // Bit offsets of each cfg field inside its 32-bit slave register
  localparam int CTRL_ENABLE_BIT    = 0;
  localparam int CTRL_PRESCALE_LSB  = 8;
  localparam int TIMING_PERIOD_LSB  = 0;
  localparam int TIMING_DUTY_LSB    = 16;
  localparam int TONE_HALF_LSB      = 0;
  localparam int TONE_BURST_LSB     = 16;

endpackage

// File: rtl/pwm_prescaler.sv
// Clock prescaler: pc runs 0..limit and emits a one-cycle tick on the last count.
// A synchronous clear holds pc at 0 and suppresses the tick.
module pwm_prescaler #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic [W-1:0] limit,
  output logic         tick
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] pc;

  // >= rather than == keeps the wrap exact even if the limit shrinks under a running count
  assign tick = !clear && (pc >= limit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= '0;
    end else if (clear || (pc >= limit)) begin
      pc <= '0;
    end else begin
      pc <= pc + ONE;
    end
  end

endmodule

// File: rtl/pwm_buzzer_led_core.sv
// LED PWM and buzzer tone-burst core driven by the register-file cfg fields.
// Shadow registers make every configuration change land on a PWM period boundary.
module pwm_buzzer_led_core
  import pwm_core_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int PRESC_W = PRESC_W_DEF
) (
  input  logic               ACLK,
  input  logic               ARESET,
  input  logic               cfg_we,
  input  logic               cfg_enable,
  input  logic [PRESC_W-1:0] cfg_prescale,
  input  logic [CNT_W-1:0]   cfg_period,
  input  logic [CNT_W-1:0]   cfg_duty,
  input  logic [CNT_W-1:0]   cfg_tone_half,
  input  logic [CNT_W-1:0]   cfg_burst,
  output logic               led_pwm,
  output logic               buzzer,
  output logic               busy,
  output logic               done,
  output logic               period_evt
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  core_state_t        state, state_n;
  logic [PRESC_W-1:0] prescale_sh;
  logic [CNT_W-1:0]   period_sh, duty_sh, tone_half_sh, burst_sh;
  logic [CNT_W-1:0]   cnt, hc, cyc;
  logic               tick, wrap, toggle, burst_end;
  logic               start, reload, load_sh, clear_pc;

  // Dropping enable always means IDLE next, so it can gate the prescaler without
  // routing the next-state logic back into the tick path.
  assign clear_pc = (state == IDLE) || !cfg_enable;

  pwm_prescaler #(.W(PRESC_W)) u_prescaler (
    .clk   (ACLK),
    .rst   (ARESET),
    .clear (clear_pc),
    .limit (prescale_sh),
    .tick  (tick)
  );

  assign wrap      = tick && (cnt >= period_sh);
  assign toggle    = (state == RUN) && tick && (tone_half_sh != '0)
                     && (hc >= tone_half_sh - ONE);
  assign burst_end = toggle && buzzer && (burst_sh != '0) && (cyc + ONE >= burst_sh);
  assign load_sh   = start || reload || wrap;

  always_comb begin
    state_n = state;
    start   = 1'b0;
    reload  = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_enable) begin
          state_n = RUN;
          start   = 1'b1;
        end
      end
      RUN: begin
        if (!cfg_enable)    state_n = IDLE;
        else if (burst_end) state_n = DONE;
      end
      DONE: begin
        if (!cfg_enable) begin
          state_n = IDLE;
        end else if (cfg_we) begin
          state_n = RUN;
          reload  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state        <= IDLE;
      prescale_sh  <= '0;
      period_sh    <= '0;
      duty_sh      <= '0;
      tone_half_sh <= '0;
      burst_sh     <= '0;
      cnt          <= '0;
      hc           <= '0;
      cyc          <= '0;
      led_pwm      <= 1'b0;
      buzzer       <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      period_evt   <= 1'b0;
    end else begin
      state <= state_n;

      if (load_sh) begin
        prescale_sh  <= cfg_prescale;
        period_sh    <= cfg_period;
        duty_sh      <= cfg_duty;
        tone_half_sh <= cfg_tone_half;
        burst_sh     <= cfg_burst;
      end

      // A DONE->RUN re-arm leaves cnt alone so the LED waveform is not disturbed
      if ((state == IDLE) || (state_n == IDLE)) begin
        cnt <= '0;
      end else if (tick) begin
        cnt <= wrap ? '0 : cnt + ONE;
      end

      if ((state_n == IDLE) || start || reload) begin
        hc  <= '0;
        cyc <= '0;
      end else if ((state == RUN) && tick && (tone_half_sh != '0)) begin
        if (toggle) begin
          hc <= '0;
          if (buzzer) cyc <= cyc + ONE;
        end else begin
          hc <= hc + ONE;
        end
      end

      if (state_n != RUN) buzzer <= 1'b0;
      else if (toggle)    buzzer <= !buzzer;

      // Require the core to be active now, so stale shadows never leak out on the start edge
      led_pwm    <= (state != IDLE) && (state_n != IDLE) && (cnt < duty_sh);
      period_evt <= wrap;
      busy       <= (state_n == RUN);
      done       <= (state_n == DONE);
    end
  end

endmodule

// File: tb/tb_pwm_buzzer_led_core.sv
// Directed bench for pwm_buzzer_led_core: hand-computed waveforms of
// {led_pwm, buzzer, busy, done, period_evt} checked one clock at a time.
module tb_pwm_buzzer_led_core;

  localparam int CNT_W   = 16;
  localparam int PRESC_W = 8;

  logic               ACLK = 1'b0;
  logic               ARESET;
  logic               cfg_we;
  logic               cfg_enable;
  logic [PRESC_W-1:0] cfg_prescale;
  logic [CNT_W-1:0]   cfg_period;
  logic [CNT_W-1:0]   cfg_duty;
  logic [CNT_W-1:0]   cfg_tone_half;
  logic [CNT_W-1:0]   cfg_burst;
  logic               led_pwm, buzzer, busy, done, period_evt;

  int errors = 0;
  int checks = 0;

  always #5 ACLK = ~ACLK;

  pwm_buzzer_led_core #(.CNT_W(CNT_W), .PRESC_W(PRESC_W)) dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .cfg_we        (cfg_we),
    .cfg_enable    (cfg_enable),
    .cfg_prescale  (cfg_prescale),
    .cfg_period    (cfg_period),
    .cfg_duty      (cfg_duty),
    .cfg_tone_half (cfg_tone_half),
    .cfg_burst     (cfg_burst),
    .led_pwm       (led_pwm),
    .buzzer        (buzzer),
    .busy          (busy),
    .done          (done),
    .period_evt    (period_evt)
  );

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic apply_stimulus(input int presc, input int period, input int duty,
                                input int tone, input int burst);
    cfg_prescale  = PRESC_W'(presc);
    cfg_period    = CNT_W'(period);
    cfg_duty      = CNT_W'(duty);
    cfg_tone_half = CNT_W'(tone);
    cfg_burst     = CNT_W'(burst);
  endtask

  // exp bit order: led, buzzer, busy, done, period_evt
  task automatic check_output(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    obs = {led_pwm, buzzer, busy, done, period_evt};
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: led/buz/busy/done/evt got %b expected %b", tag, obs, exp);
    end
  endtask

  // Patterns are written first-clock-leftmost: bit n-1 is the first clock checked
  task automatic check_seq(input string tag, input int n, input logic [31:0] led,
                           input logic [31:0] buz, input logic [31:0] bsy,
                           input logic [31:0] dn, input logic [31:0] evt);
    for (int i = 0; i < n; i++) begin
      int b;
      b = n - 1 - i;
      step();
      check_output($sformatf("%s[%0d]", tag, i), {led[b], buz[b], bsy[b], dn[b], evt[b]});
    end
  endtask

  initial begin
    ARESET     = 1'b1;
    cfg_we     = 1'b0;
    cfg_enable = 1'b0;
    apply_stimulus(0, 0, 0, 0, 0);
    step();
    step();
    check_output("reset", 5'b00000);
    ARESET = 1'b0;
    step();
    check_output("idle", 5'b00000);

    // Basic PWM 1000
    apply_stimulus(0, 3, 1, 0, 0);
    cfg_enable = 1'b1;
    step();
    check_output("start_basic", 5'b00100);
    check_seq("basic", 8, 8'b10001000, 0, 8'hFF, 0, 8'b00010001);
    cfg_enable = 1'b0;
    step();
    check_output("stop_basic", 5'b00000);

    // Duty extremes
    apply_stimulus(0, 3, 0, 0, 0);
    cfg_enable = 1'b1;
    step();
    check_output("start_duty0", 5'b00100);
    check_seq("duty0", 8, 8'b00000000, 0, 8'hFF, 0, 8'b00010001);
    cfg_enable = 1'b0;
    step();
    check_output("stop_duty0", 5'b00000);

    apply_stimulus(0, 3, 4, 0, 0);
    cfg_enable = 1'b1;
    step();
    check_output("start_duty4", 5'b00100);
    check_seq("duty4", 8, 8'b11111111, 0, 8'hFF, 0, 8'b00010001);
    cfg_enable = 1'b0;
    step();
    check_output("stop_duty4", 5'b00000);

    // Prescale 2: three clocks per tick
    apply_stimulus(2, 1, 1, 0, 0);
    cfg_enable = 1'b1;
    step();
    check_output("start_presc", 5'b00100);
    check_seq("presc", 12, 12'b111000111000, 0, 12'hFFF, 0, 12'b000001000001);
    cfg_enable = 1'b0;
    step();
    check_output("stop_presc", 5'b00000);

    // Mid-period duty change lands at the next wrap
    apply_stimulus(0, 3, 1, 0, 0);
    cfg_enable = 1'b1;
    step();
    check_output("start_glitch", 5'b00100);
    step();
    check_output("glitch_first_high", 5'b10100);
    cfg_duty = 16'd3;
    cfg_we   = 1'b1;
    step();
    check_output("glitch_we", 5'b00100);
    cfg_we = 1'b0;
    check_seq("glitch", 6, 6'b001110, 0, 6'h3F, 0, 6'b010001);
    cfg_enable = 1'b0;
    step();
    check_output("stop_glitch", 5'b00000);

    // Burst of three tone cycles, wrap coincides with completion
    apply_stimulus(0, 3, 1, 2, 3);
    cfg_enable = 1'b1;
    step();
    check_output("start_burst", 5'b00100);
    check_seq("burst", 12, 12'b100010001000, 12'b011001100110, 12'b111111111110,
              12'b000000000001, 12'b000100010001);
    check_seq("done_hold", 4, 4'b1000, 0, 0, 4'hF, 4'b0001);
    cfg_we = 1'b1;
    step();
    check_output("rearm", 5'b10100);
    cfg_we = 1'b0;
    check_seq("reburst", 6, 6'b000100, 6'b011001, 6'h3F, 0, 6'b001000);

    // Abort mid-burst while the buzzer is high
    cfg_enable = 1'b0;
    step();
    check_output("abort", 5'b00000);
    step();
    check_output("abort_idle", 5'b00000);

    // Asynchronous reset mid-period, then restart from cnt=0
    apply_stimulus(0, 3, 1, 0, 0);
    cfg_enable = 1'b1;
    step();
    check_output("start_rst", 5'b00100);
    step();
    check_output("pre_rst", 5'b10100);
    #2;
    ARESET = 1'b1;
    #1;
    check_output("async_rst", 5'b00000);
    step();
    check_output("rst_held", 5'b00000);
    ARESET = 1'b0;
    step();
    check_output("restart", 5'b00100);
    check_seq("after_rst", 5, 5'b10001, 0, 5'h1F, 0, 5'b00010);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
